mips_mul_div_unit: RTL
======================

# mips_mul_div_unit

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS core. It sits downstream of the register file and consumes the two read-port operands (RS from read port 1, RT from read port 2) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It holds busy while an operation iterates. HI/LO are exposed to the writeback mux for MFHI/MFLO.

## Interface
- No module parameters. Width is Data_Width from the shared generic package (32). Iteration count is the package constant MD_Iterations = Data_Width.
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  launch the operation in op. Sampled only when busy=0.
- op  in  md_op_t (3 b)  MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO.
- RS  in  Data_Width  operand A (dividend / multiplicand / MTHI-MTLO source).
- RT  in  Data_Width  operand B (divisor / multiplier).
- flush  in  1  synchronous abort of an in-flight operation.
- busy  out  1  operation in progress; the pipeline stalls MD ops and MFHI/MFLO while high.
- done  out  1  one-cycle pulse; HI/LO hold the new result in the same cycle.
- div_by_zero  out  1  one-cycle pulse coincident with done for DIV/DIVU with RT=0.
- HI  out  Data_Width  architectural HI register.
- LO  out  Data_Width  architectural LO register.

## Operation
- FSM states (md_state_t): IDLE, RUN, FIX.
- **IDLE**
  - start with MULT/MULTU/DIV/DIVU: latch operand magnitudes (signed ops: two's-complement abs; unsigned ops: raw), result sign = A[31]^B[31], remainder sign = A[31] (signed ops only), op class. Clear the iteration counter. Go to RUN.
  - start with MTHI/MTLO: HI (or LO) <= RS on that edge. Stay IDLE. No busy, no done.
- **RUN**: 32 iterations, one per clock.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring step; 32-bit partial remainder plus quotient shift register.
  - Counter reaches 31: go to FIX.
- **FIX**: one cycle.
  - Apply sign correction (negate product / quotient / remainder as required).
  - Write {HI,LO}: product = {hi,lo}; divide: LO = quotient, HI = remainder.
  - Go to IDLE.
- **Divide by zero**: runs the full latency. Result is LO = 0xFFFFFFFF, HI = RS (original, uncorrected). div_by_zero pulses.
- **Overflow**: DIV 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0, with no flag. This falls out of unsigned magnitude arithmetic.
- **start while busy**: ignored; no queueing.
- **flush in RUN or FIX**: return to IDLE on the next edge. HI/LO unchanged, no done. flush in IDLE has no effect; same-cycle start+flush in IDLE: flush wins, start ignored.
- **rst_n low at any time**: state IDLE, HI = LO = 0, busy = done = div_by_zero = 0, counter and datapath registers 0. An in-flight operation is lost.

## Timing
- Edge E0 samples start in IDLE. busy is high from after E0 until after E33 (33 cycles).
- RUN occupies E1..E32. FIX executes at E33.
- After E33: HI/LO valid, done = 1 and busy = 0 for one cycle. A new start may be accepted on E34.
- Total latency start-to-result: 34 edges, identical for all four arithmetic ops.
- MTHI/MTLO: result visible after E0 (1 edge).
- busy, done and div_by_zero are registered outputs; nothing combinational from inputs to outputs.

## Structure
- Shared package additions: md_op_t enum, md_state_t enum, MD_Iterations constant, plus functions md_abs(x) and md_neg(x) (two's complement on Data_Width).
- Data_Width is reused from the generic package.
- Single module. Optional sub-module mips_md_step (combinational one-iteration shift-add/restore step) is natural if the datapath is shared between MUL and DIV.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI = 0xFFFFFFFE, LO = 0x00000001. done exactly after E33; busy high 33 cycles.
- MULT 0xFFFFFFFD (−3) × 7 -> HI = 0xFFFFFFFF, LO = 0xFFFFFFEB (−21). MULT 0x80000000 × 0x80000000 -> HI = 0x40000000, LO = 0.
- DIV −7 / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. DIVU 7 / 2 -> LO = 3, HI = 1. DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 5 / 0 -> LO = 0xFFFFFFFF, HI = 5, div_by_zero and done pulse together for 1 cycle.
- MTHI 0x1234 then MTLO 0xABCD on consecutive cycles -> HI = 0x1234, LO = 0xABCD after 1 edge each; busy and done stay 0. A second start issued mid-RUN is ignored: original result intact, single done.
- flush at E10 of a MULT -> busy low after E11, no done, HI/LO keep prior values. rst_n asserted at E20 of a DIV -> HI = LO = 0 and busy = 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mips_mul_div_unit_pkg.sv
// Shared types, constants and two's-complement helpers for the MIPS
// multiply/divide unit.
package mips_mul_div_unit_pkg;

  localparam int Data_Width    = 32;
  localparam int MD_Iterations = Data_Width;
  localparam int MD_Cnt_Width  = $clog2(MD_Iterations);

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  function automatic logic [Data_Width-1:0] md_neg(input logic [Data_Width-1:0] x);
    return ~x + Data_Width'(1);
  endfunction

  function automatic logic [Data_Width-1:0] md_abs(input logic [Data_Width-1:0] x);
    return x[Data_Width-1] ? md_neg(x) : x;
  endfunction

endpackage

// File: rtl/mips_mul_div_unit_if.sv
// Pipeline-side bundle of the multiply/divide unit: request, status and
// the architectural HI/LO values.
interface mips_mul_div_unit_if;
  import mips_mul_div_unit_pkg::*;

  logic                  start;
  md_op_t                op;
  logic [Data_Width-1:0] RS;
  logic [Data_Width-1:0] RT;
  logic                  flush;
  logic                  busy;
  logic                  done;
  logic                  div_by_zero;
  logic [Data_Width-1:0] HI;
  logic [Data_Width-1:0] LO;

  modport master (
    output start, op, RS, RT, flush,
    input  busy, done, div_by_zero, HI, LO
  );

  modport slave (
    input  start, op, RS, RT, flush,
    output busy, done, div_by_zero, HI, LO
  );

endinterface

// File: rtl/mips_mul_div_unit.sv
// Iterative 32-cycle multiply/divide on operand magnitudes with a final
// sign-correction cycle; owns the architectural HI/LO registers.
//
// state | meaning
// IDLE  | waiting for start; MTHI/MTLO write HI/LO directly
// RUN   | one shift-add or restoring-divide step per clock
// FIX   | sign correction, HI/LO write, done pulse
module mips_mul_div_unit
  import mips_mul_div_unit_pkg::*;
(
  input logic                clk,
  input logic                rst_n,
  mips_mul_div_unit_if.slave md
);

  md_state_t                 state;
  logic [MD_Cnt_Width-1:0]   cnt;
  // acc holds {upper product, multiplier} or {partial remainder, quotient}
  logic [2*Data_Width-1:0]   acc;
  logic [Data_Width-1:0]     opb;
  logic [Data_Width-1:0]     raw_a;
  logic                      is_div;
  logic                      neg_res;
  logic                      neg_rem;
  logic                      div0;
  logic [Data_Width-1:0]     hi_q;
  logic [Data_Width-1:0]     lo_q;
  logic                      busy_q;
  logic                      done_q;
  logic                      dz_q;

  logic                      op_signed;
  logic                      op_div;
  logic                      op_arith;
  logic [Data_Width-1:0]     a_mag;
  logic [Data_Width-1:0]     b_mag;
  logic [Data_Width-1:0]     addend;
  logic [Data_Width:0]       mul_sum;
  logic [Data_Width:0]       div_shift;
  logic                      div_ge;
  logic [Data_Width-1:0]     div_sub;
  logic [2*Data_Width-1:0]   acc_next;
  logic [2*Data_Width-1:0]   prod;
  logic [Data_Width-1:0]     quot;
  logic [Data_Width-1:0]     rem;

  always_comb begin
    op_signed = (md.op == MD_MULT) || (md.op == MD_DIV);
    op_div    = (md.op == MD_DIV)  || (md.op == MD_DIVU);
    op_arith  = op_div || (md.op == MD_MULT) || (md.op == MD_MULTU);
    a_mag     = op_signed ? md_abs(md.RS) : md.RS;
    b_mag     = op_signed ? md_abs(md.RT) : md.RT;

    addend    = acc[0] ? opb : '0;
    mul_sum   = {1'b0, acc[2*Data_Width-1:Data_Width]} + {1'b0, addend};

    div_shift = acc[2*Data_Width-1:Data_Width-1];
    div_ge    = div_shift >= {1'b0, opb};
    // true difference is below 2^32 whenever div_ge, so truncation is exact
    div_sub   = div_shift[Data_Width-1:0] - opb;

    if (is_div)
      acc_next = div_ge ? {div_sub, acc[Data_Width-2:0], 1'b1}
                        : {div_shift[Data_Width-1:0], acc[Data_Width-2:0], 1'b0};
    else
      acc_next = {mul_sum, acc[Data_Width-1:1]};

    prod = neg_res ? (~acc + (2*Data_Width)'(1)) : acc;
    quot = neg_res ? md_neg(acc[Data_Width-1:0]) : acc[Data_Width-1:0];
    rem  = neg_rem ? md_neg(acc[2*Data_Width-1:Data_Width])
                   : acc[2*Data_Width-1:Data_Width];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      acc     <= '0;
      opb     <= '0;
      raw_a   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        IDLE: begin
          if (md.start && !md.flush) begin
            if (op_arith) begin
              state   <= RUN;
              busy_q  <= 1'b1;
              cnt     <= '0;
              is_div  <= op_div;
              neg_res <= op_signed && (md.RS[Data_Width-1] ^ md.RT[Data_Width-1]);
              neg_rem <= op_signed && md.RS[Data_Width-1];
              div0    <= op_div && (md.RT == '0);
              raw_a   <= md.RS;
              if (op_div) begin
                acc <= {{Data_Width{1'b0}}, a_mag};
                opb <= b_mag;
              end else begin
                acc <= {{Data_Width{1'b0}}, b_mag};
                opb <= a_mag;
              end
            end else if (md.op == MD_MTHI) begin
              hi_q <= md.RS;
            end else if (md.op == MD_MTLO) begin
              lo_q <= md.RS;
            end
          end
        end
        RUN: begin
          if (md.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc <= acc_next;
            cnt <= cnt + MD_Cnt_Width'(1);
            if (cnt == MD_Cnt_Width'(MD_Iterations - 1))
              state <= FIX;
          end
        end
        FIX: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          if (!md.flush) begin
            done_q <= 1'b1;
            dz_q   <= div0;
            if (!is_div) begin
              hi_q <= prod[2*Data_Width-1:Data_Width];
              lo_q <= prod[Data_Width-1:0];
            end else if (div0) begin
              hi_q <= raw_a;
              lo_q <= '1;
            end else begin
              hi_q <= rem;
              lo_q <= quot;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign md.busy        = busy_q;
  assign md.done        = done_q;
  assign md.div_by_zero = dz_q;
  assign md.HI          = hi_q;
  assign md.LO          = lo_q;

endmodule
